// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and merge rule for the comparator reduction tree
// A node result is an (eq, lt) pair describing a-vs-b over the bits it covers.
package cmp_pkg;

  localparam int CMP_WIDTH = 32;

  typedef struct packed {
    logic eq;
    logic lt;
  } cmp_res_t;

  // Leaf result for one bit position of a and b.
  function automatic cmp_res_t cmp_leaf(input logic a, input logic b);
    cmp_res_t r;
    r.eq = ~(a ^ b);
    r.lt = ~a & b;
    return r;
  endfunction

  // The more-significant half decides unless it is equal, then the lower half does.
  function automatic cmp_res_t cmp_merge(input cmp_res_t hi, input cmp_res_t lo);
    cmp_res_t r;
    r.eq = hi.eq & lo.eq;
    r.lt = hi.lt | (hi.eq & lo.lt);
    return r;
  endfunction

endpackage

// File: rtl/cmp_tree_node.sv
// rtl/cmp_tree_node.sv - one reduction level: merges N (hi, lo) pairs into N results
// Purely combinational; the top chains log2(WIDTH) of these.
module cmp_tree_node
  import cmp_pkg::*;
#(
  parameter int N = 1
) (
  input  cmp_res_t [N-1:0] hi_i,
  input  cmp_res_t [N-1:0] lo_i,
  output cmp_res_t [N-1:0] res_o
);

  for (genvar j = 0; j < N; j++) begin : g_merge
    assign res_o[j] = cmp_merge(hi_i[j], lo_i[j]);
  end

endmodule

// File: rtl/comparator_tree32.sv
// rtl/comparator_tree32.sv - registered EQ / signed LT / unsigned LT of op1 vs op2
// Bit-level leaves reduced by a log2(WIDTH)-deep tree; only the outputs are registered.
module comparator_tree32
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             EQ,
  output logic             LT,
  output logic             LTu
);

  // WIDTH must be a power of two and at least 2 so every level pairs up evenly.
  localparam int DEPTH = $clog2(WIDTH);

  cmp_res_t [WIDTH-1:0] leaf;

  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    assign leaf[i] = cmp_leaf(op1[i], op2[i]);
  end

  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int N = WIDTH >> (l + 1);
    cmp_res_t [N-1:0] hi;
    cmp_res_t [N-1:0] lo;
    cmp_res_t [N-1:0] res;

    for (genvar j = 0; j < N; j++) begin : g_pair
      if (l == 0) begin : g_from_leaf
        assign hi[j] = leaf[2*j+1];
        assign lo[j] = leaf[2*j];
      end else begin : g_from_prev
        assign hi[j] = g_lvl[l-1].res[2*j+1];
        assign lo[j] = g_lvl[l-1].res[2*j];
      end
    end

    cmp_tree_node #(
      .N (N)
    ) u_node (
      .hi_i  (hi),
      .lo_i  (lo),
      .res_o (res)
    );
  end

  cmp_res_t root;
  logic     lt_s;

  assign root = g_lvl[DEPTH-1].res[0];

  // With differing sign bits the negative operand (MSB set) is the smaller one.
  assign lt_s = (op1[WIDTH-1] ^ op2[WIDTH-1]) ? op1[WIDTH-1] : root.lt;

  logic eq_d,  eq_q;
  logic lt_d,  lt_q;
  logic ltu_d, ltu_q;

  assign eq_d  = root.eq;
  assign lt_d  = lt_s;
  assign ltu_d = root.lt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      ltu_q <= 1'b0;
    end else begin
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      ltu_q <= ltu_d;
    end
  end

  assign EQ  = eq_q;
  assign LT  = lt_q;
  assign LTu = ltu_q;

endmodule

// File: tb/tb_comparator_tree32.sv
// tb/tb_comparator_tree32.sv - directed and random checks of comparator_tree32
// Expected results come from plain integer comparisons on the operands.
module tb_comparator_tree32;

  logic        clk;
  logic        reset_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        EQ;
  logic        LT;
  logic        LTu;

  int tests_run;
  int tests_failed;

  comparator_tree32 #(
    .WIDTH (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .op1     (op1),
    .op2     (op2),
    .EQ      (EQ),
    .LT      (LT),
    .LTu     (LTu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check3(input string tag, input logic e_eq, input logic e_lt, input logic e_ltu);
    check_bit({tag, ".EQ"},  EQ,  e_eq);
    check_bit({tag, ".LT"},  LT,  e_lt);
    check_bit({tag, ".LTu"}, LTu, e_ltu);
  endtask

  // Drive one pair, let the edge capture it, then sample just after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b);
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag, input logic [31:0] a, input logic [31:0] b);
    check3(tag, a == b, $signed(a) < $signed(b), a < b);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] base;
    logic        e_ltu;
    int          reset_at;

    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    op1          = '0;
    op2          = '0;

    step(32'h0, 32'h0);
    check3("reset_c1", 1'b0, 1'b0, 1'b0);
    step(32'h0, 32'h0);
    check3("reset_c2", 1'b0, 1'b0, 1'b0);

    reset_n = 1'b1;
    step(32'h0000_0000, 32'h0000_0000);
    check3("zero_eq", 1'b1, 1'b0, 1'b0);

    step(32'h8000_0000, 32'h0000_0001);
    check3("split_neg_vs_pos", 1'b0, 1'b1, 1'b0);
    step(32'h0000_0001, 32'h8000_0000);
    check3("split_pos_vs_neg", 1'b0, 1'b0, 1'b1);

    step(32'h7FFF_FFFE, 32'h7FFF_FFFF);
    check3("adj_pos", 1'b0, 1'b1, 1'b1);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check3("adj_neg", 1'b0, 1'b0, 1'b0);

    step(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check3("all_ones_eq", 1'b1, 1'b0, 1'b0);

    // A single differing bit exercises each path from leaf to root.
    base = 32'h1234_5678;
    for (int k = 0; k < 32; k++) begin
      b = base ^ (32'h1 << k);
      step(base, b);
      e_ltu = ~base[k];
      check3($sformatf("bit%0d", k), 1'b0, (k == 31) ? ~e_ltu : e_ltu, e_ltu);
    end

    reset_at = 3000 + int'($urandom_range(0, 2000));
    for (int i = 0; i < 8192; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        2: b = {~a[31], a[30:0]};
        default: ;
      endcase
      if (i == reset_at) begin
        reset_n = 1'b0;
        step(a, b);
        check3("midrun_reset", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
      end else begin
        step(a, b);
        check_model($sformatf("rand%0d", i), a, b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
